hyperbus_resp: RTL

HYPERBUS_RESP -- requirements
Module: hyperbus_resp

---
 rtl/hyperbus_resp.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hyperbus_resp.sv
// HyperBus responder: decodes the command-address phase, waits out the
// initial latency and then streams read or write bursts to a single-cycle
// memory port. Register space holds one 16-bit configuration register.
module hyperbus_resp #(
    parameter int unsigned MemAddrWidth  = 16,
    parameter int unsigned LatencyCycles = 6,
    parameter bit          DoubleLatency = 1'b1,
    parameter logic [15:0] RstCfgReg     = 16'h8F1F
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    hyper_cs_ni,
    input  logic [15:0]             hyper_dq_i,
    input  logic [1:0]              hyper_rwds_i,
    output logic [15:0]             hyper_dq_o,
    output logic                    hyper_dq_oe_o,
    output logic [1:0]              hyper_rwds_o,
    output logic                    hyper_rwds_oe_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [1:0]              mem_be_o,
    output logic [15:0]             mem_wdata_o,
    input  logic [15:0]             mem_rdata_i
);

    localparam int unsigned LatTotal = LatencyCycles * (DoubleLatency ? 2 : 1);
    localparam int unsigned LatW     = 5;
    localparam logic [MemAddrWidth-1:0] WrapMask = MemAddrWidth'(15);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CA    = 3'd1,
        S_LAT   = 3'd2,
        S_RD    = 3'd3,
        S_WR    = 3'd4,
        S_REGWR = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e                  state_q;
    logic                    armed_q;
    logic                    ca_cnt_q;
    logic [47:16]            ca_q;
    logic [LatW-1:0]         lat_cnt_q;
    logic [MemAddrWidth-1:0] addr_q;
    logic [15:0]             cfg_q;

    logic                    ca_read;
    logic                    ca_reg;
    logic                    ca_linear;
    logic                    lat_last;
    logic                    run;
    logic [MemAddrWidth-1:0] start_addr;
    logic [MemAddrWidth-1:0] next_addr;

    // Command decode and address arithmetic shared by sequencer and outputs
    always_comb begin
        ca_read    = ca_q[47];
        ca_reg     = ca_q[46];
        ca_linear  = ca_q[45];
        lat_last   = (lat_cnt_q == '0);
        run        = rst_ni & ~hyper_cs_ni;
        start_addr = MemAddrWidth'({ca_q[44:16], hyper_dq_i[2:0]});
        if (ca_linear) begin
            next_addr = addr_q + MemAddrWidth'(1);
        end else begin
            next_addr = (addr_q & ~WrapMask) | ((addr_q + MemAddrWidth'(1)) & WrapMask);
        end
    end

    // Transaction sequencer; a new transaction needs chip select seen high first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            ca_cnt_q  <= 1'b0;
            ca_q      <= '0;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            cfg_q     <= RstCfgReg;
        end else if (hyper_cs_ni) begin
            state_q <= S_IDLE;
            armed_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        ca_q[47:32] <= hyper_dq_i;
                        ca_cnt_q    <= 1'b0;
                        state_q     <= S_CA;
                    end
                end
                S_CA: begin
                    if (!ca_cnt_q) begin
                        ca_q[31:16] <= hyper_dq_i;
                        ca_cnt_q    <= 1'b1;
                    end else begin
                        addr_q <= start_addr;
                        if (!ca_read && ca_reg) begin
                            state_q <= S_REGWR;
                        end else begin
                            lat_cnt_q <= LatW'(LatTotal - 1);
                            state_q   <= S_LAT;
                        end
                    end
                end
                S_LAT: begin
                    if (lat_last) begin
                        // Reads prefetch the start address in this cycle
                        if (ca_read) begin
                            addr_q  <= next_addr;
                            state_q <= S_RD;
                        end else begin
                            state_q <= S_WR;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - LatW'(1);
                    end
                end
                S_RD: begin
                    addr_q <= next_addr;
                end
                S_WR: begin
                    addr_q <= next_addr;
                end
                S_REGWR: begin
                    cfg_q   <= hyper_dq_i;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Bus and memory outputs, forced low whenever chip select is high or in reset
    always_comb begin
        hyper_dq_o      = '0;
        hyper_dq_oe_o   = 1'b0;
        hyper_rwds_o    = '0;
        hyper_rwds_oe_o = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_be_o        = '0;
        mem_wdata_o     = '0;
        if (run) begin
            case (state_q)
                S_IDLE: begin
                    if (armed_q) begin
                        hyper_rwds_oe_o = 1'b1;
                        hyper_rwds_o    = {2{DoubleLatency}};
                    end
                end
                S_CA: begin
                    hyper_rwds_oe_o = 1'b1;
                    hyper_rwds_o    = {2{DoubleLatency}};
                end
                S_LAT: begin
                    if (lat_last && ca_read && !ca_reg) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = addr_q;
                    end
                end
                S_RD: begin
                    hyper_dq_oe_o   = 1'b1;
                    hyper_rwds_oe_o = 1'b1;
                    hyper_rwds_o    = 2'b10;
                    hyper_dq_o      = ca_reg ? cfg_q : mem_rdata_i;
                    if (!ca_reg) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = addr_q;
                    end
                end
                S_WR: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_q;
                    mem_be_o    = ~hyper_rwds_i;
                    mem_wdata_o = hyper_dq_i;
                end
                default: begin
                    mem_req_o = 1'b0;
                end
            endcase
        end
    end

endmodule
